// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU M-stage vs DMA/debug requester, one access per cycle.
// Define DM_ARB_RR_EN for round-robin contention; default is CPU priority with a starvation counter.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_sign,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_width,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

  owner_e      owner;
  logic        dma_wins;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef DM_ARB_RR_EN
  logic last_cpu_q, last_cpu_d;

  // Under contention the side that was not served last takes the port.
  assign dma_wins = last_cpu_q;

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (owner == OWN_CPU) last_cpu_d = 1'b1;
    else if (owner == OWN_DMA) last_cpu_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_cpu_q <= 1'b1;
    else        last_cpu_q <= last_cpu_d;
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign dma_wins = (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (!dma_req || owner == OWN_DMA) starve_d = '0;
    else if (starve_q != LIMIT)       starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  // Gating with reset aborts any grant in the cycle reset is asserted.
  always_comb begin
    owner = OWN_NONE;
    if (reset) begin
      if (cpu_req && dma_req) owner = dma_wins ? OWN_DMA : OWN_CPU;
      else if (cpu_req)       owner = OWN_CPU;
      else if (dma_req)       owner = OWN_DMA;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = '0;
    mem_sign  = 1'b0;
    case (owner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_width = cpu_width;
        mem_sign  = cpu_sign;
      end
      OWN_DMA: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_width = dma_width;
      end
      default: ;
    endcase
  end

  assign dma_gnt   = (owner == OWN_DMA);
  assign cpu_stall = cpu_req && (owner == OWN_DMA);
  assign cpu_rdata = mem_rdata;

  always_comb begin
    rvalid_d = dma_gnt && !dma_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;

endmodule
